motor_drive: RTL and testbench

MOTOR_DRIVE -- requirements
Module: motor_drive

---
 rtl/motor_drive.sv | 212 +++++++++++++++++++++
 tb/tb_motor_drive.sv | 553 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_drive.sv
// ---------------------------------------------------------------------------
// motor_drive
//
// Dual-channel H-bridge driver with dead-time protection and soft-start PWM.
// Each channel (left = 1, right = 0) runs its own IDLE/RUN/DEAD machine.
// A direction reversal or a stop always spends DEAD_CYCLES clocks with both
// bridge inputs low. The PWM duty ramps toward the requested duty by at most
// RAMP_STEP per PWM period.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   motorIn     direction request, [3:2] left, [1:0] right
//               (10 = dir A, 01 = dir B, 00 = coast, 11 = illegal)
//   motorEn     run request, [1] left, [0] right
//   duty        target duty shared by both channels
//   bridge_in   H-bridge direction pins, same mapping as motorIn
//   bridge_pwm  H-bridge enable PWM, [1] left, [0] right
//   dir_fault   sticky illegal-direction flag, [1] left, [0] right
// ---------------------------------------------------------------------------
module motor_drive #(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 16,
    parameter int RAMP_STEP   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          motorIn,
    input  logic [1:0]          motorEn,
    input  logic [PWM_BITS-1:0] duty,
    output logic [3:0]          bridge_in,
    output logic [1:0]          bridge_pwm,
    output logic [1:0]          dir_fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    // The dead counter counts down to zero; loading N-1 gives exactly N
    // clocks between DEAD entry and the exit edge.
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

    localparam int PWM_MAX    = (1 << PWM_BITS) - 1;
    localparam int STEP_CLAMP = (RAMP_STEP > PWM_MAX) ? PWM_MAX : RAMP_STEP;
    localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(STEP_CLAMP);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    // -----------------------------------------------------------------------
    // Input capture: the raw inputs may glitch, so every decision is made on
    // these registered copies.
    // -----------------------------------------------------------------------
    logic [3:0]          in_reg;
    logic [1:0]          en_reg;
    logic [PWM_BITS-1:0] duty_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_reg   <= '0;
            en_reg   <= '0;
            duty_reg <= '0;
        end else begin
            in_reg   <= motorIn;
            en_reg   <= motorEn;
            duty_reg <= duty;
        end
    end

    // -----------------------------------------------------------------------
    // Shared free-running PWM counter
    // -----------------------------------------------------------------------
    logic [PWM_BITS-1:0] cnt_reg;
    logic [PWM_BITS-1:0] cnt_next;
    logic                wrap;

    assign cnt_next = cnt_reg + PWM_BITS'(1);
    assign wrap     = (cnt_reg == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel FSM, ramp and PWM
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
        logic [1:0]          dir;
        logic                en;
        logic                legal;
        logic                illegal;
        state_t              state_reg;
        logic [1:0]          dir_lat_reg;
        logic [1:0]          pair_reg;
        logic [DEAD_W-1:0]   dead_reg;
        logic [PWM_BITS-1:0] cur_duty_reg;
        logic [PWM_BITS-1:0] ramp_val;
        logic [PWM_BITS-1:0] diff;
        logic                pwm_reg;
        logic                fault_reg;

        assign dir     = in_reg[2*gi +: 2];
        assign en      = en_reg[gi];
        assign legal   = (dir == 2'b10) || (dir == 2'b01);
        assign illegal = en && (dir == 2'b11);

        // Next ramp value: step toward the target, landing exactly on it when
        // the remaining gap is smaller than one step.
        always_comb begin
            ramp_val = duty_reg;
            diff     = '0;
            if (duty_reg > cur_duty_reg) begin
                diff = duty_reg - cur_duty_reg;
                if (diff > STEP) begin
                    ramp_val = cur_duty_reg + STEP;
                end
            end else if (duty_reg < cur_duty_reg) begin
                diff = cur_duty_reg - duty_reg;
                if (diff > STEP) begin
                    ramp_val = cur_duty_reg - STEP;
                end
            end
        end

        // The PWM bit is computed from the values the counter and cur_duty
        // take at this same edge, so the pin always equals
        // (state == RUN && counter < cur_duty) with no extra clock of lag.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_reg    <= ST_IDLE;
                dir_lat_reg  <= 2'b00;
                pair_reg     <= 2'b00;
                dead_reg     <= '0;
                cur_duty_reg <= '0;
                pwm_reg      <= 1'b0;
                fault_reg    <= 1'b0;
            end else begin
                // Inputs are ignored mid-DEAD; they are looked at only on the
                // expiry edge.
                if (illegal && ((state_reg != ST_DEAD) || (dead_reg == '0))) begin
                    fault_reg <= 1'b1;
                end

                case (state_reg)
                    ST_IDLE: begin
                        pair_reg     <= 2'b00;
                        pwm_reg      <= 1'b0;
                        cur_duty_reg <= '0;
                        if (en && legal) begin
                            state_reg   <= ST_RUN;
                            dir_lat_reg <= dir;
                            pair_reg    <= dir;
                        end
                    end

                    ST_RUN: begin
                        // Any stop, direction change, coast or illegal code
                        // passes through DEAD so 10 <-> 01 is never direct.
                        if (!en || (dir != dir_lat_reg)) begin
                            state_reg    <= ST_DEAD;
                            pair_reg     <= 2'b00;
                            pwm_reg      <= 1'b0;
                            cur_duty_reg <= '0;
                            dead_reg     <= DEAD_LOAD;
                        end else if (wrap) begin
                            // Counter restarts at 0 on this edge.
                            cur_duty_reg <= ramp_val;
                            pwm_reg      <= (ramp_val != '0);
                        end else begin
                            pwm_reg <= (cnt_next < cur_duty_reg);
                        end
                    end

                    ST_DEAD: begin
                        pair_reg     <= 2'b00;
                        pwm_reg      <= 1'b0;
                        cur_duty_reg <= '0;
                        if (dead_reg == '0) begin
                            if (en && legal) begin
                                state_reg   <= ST_RUN;
                                dir_lat_reg <= dir;
                                pair_reg    <= dir;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            dead_reg <= dead_reg - DEAD_W'(1);
                        end
                    end

                    default: begin
                        state_reg    <= ST_IDLE;
                        pair_reg     <= 2'b00;
                        pwm_reg      <= 1'b0;
                        cur_duty_reg <= '0;
                    end
                endcase
            end
        end

        assign bridge_in[2*gi +: 2] = pair_reg;
        assign bridge_pwm[gi]       = pwm_reg;
        assign dir_fault[gi]        = fault_reg;
    end

endmodule

// File: tb/tb_motor_drive.sv
// ---------------------------------------------------------------------------
// tb_motor_drive
//
// Self-checking bench for motor_drive. Directed scenarios check the
// behaviour against fixed expected numbers (latency, dead time, ramp
// values, duty boundaries, faults, reset). A randomized scenario runs the
// design in lockstep with a cycle-level behavioural model that tracks the
// elapsed clock count, absolute dead-time deadlines and integer duties.
// ---------------------------------------------------------------------------
module tb_motor_drive;

    localparam int PB     = 8;
    localparam int DC     = 16;
    localparam int RS     = 32;
    localparam int PERIOD = 1 << PB;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] motorIn = 4'b0000;
    logic [1:0] motorEn = 2'b00;
    logic [7:0] duty    = 8'd0;
    logic [3:0] bridge_in;
    logic [1:0] bridge_pwm;
    logic [1:0] dir_fault;

    motor_drive #(
        .PWM_BITS   (PB),
        .DEAD_CYCLES(DC),
        .RAMP_STEP  (RS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .motorIn   (motorIn),
        .motorEn   (motorEn),
        .duty      (duty),
        .bridge_in (bridge_in),
        .bridge_pwm(bridge_pwm),
        .dir_fault (dir_fault)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // -----------------------------------------------------------------------
    // Behavioural reference model
    // -----------------------------------------------------------------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DEAD = 2;

    int m_cyc;        // clock edges since reset release
    int m_in_q;
    int m_en_q;
    int m_duty_q;
    int m_state[2];
    int m_dir[2];
    int m_dead_end[2];  // absolute edge number at which DEAD expires
    int m_cur[2];
    int m_fault[2];

    function automatic void model_reset();
        m_cyc    = 0;
        m_in_q   = 0;
        m_en_q   = 0;
        m_duty_q = 0;
        for (int ch = 0; ch < 2; ch++) begin
            m_state[ch]    = M_IDLE;
            m_dir[ch]      = 0;
            m_dead_end[ch] = 0;
            m_cur[ch]      = 0;
            m_fault[ch]    = 0;
        end
    endfunction

    function automatic void model_step();
        int old_ctr;
        old_ctr = m_cyc % PERIOD;
        m_cyc   = m_cyc + 1;
        for (int ch = 0; ch < 2; ch++) begin
            int d;
            int e;
            int gap;
            bit legal;
            bit bad;
            d     = (m_in_q >> (2 * ch)) & 3;
            e     = (m_en_q >> ch) & 1;
            legal = (d == 1) || (d == 2);
            bad   = (e == 1) && (d == 3);
            case (m_state[ch])
                M_IDLE: begin
                    if (bad) m_fault[ch] = 1;
                    if (e == 1 && legal) begin
                        m_state[ch] = M_RUN;
                        m_dir[ch]   = d;
                        m_cur[ch]   = 0;
                    end
                end
                M_RUN: begin
                    if (bad) m_fault[ch] = 1;
                    if (e == 0 || d != m_dir[ch]) begin
                        m_state[ch]    = M_DEAD;
                        m_dead_end[ch] = m_cyc + DC;
                        m_cur[ch]      = 0;
                    end else if (old_ctr == PERIOD - 1) begin
                        if (m_duty_q >= m_cur[ch]) begin
                            gap       = m_duty_q - m_cur[ch];
                            m_cur[ch] = m_cur[ch] + ((gap < RS) ? gap : RS);
                        end else begin
                            gap       = m_cur[ch] - m_duty_q;
                            m_cur[ch] = m_cur[ch] - ((gap < RS) ? gap : RS);
                        end
                    end
                end
                default: begin
                    if (m_cyc == m_dead_end[ch]) begin
                        if (bad) m_fault[ch] = 1;
                        if (e == 1 && legal) begin
                            m_state[ch] = M_RUN;
                            m_dir[ch]   = d;
                        end else begin
                            m_state[ch] = M_IDLE;
                        end
                        m_cur[ch] = 0;
                    end
                end
            endcase
        end
        m_in_q   = motorIn;
        m_en_q   = motorEn;
        m_duty_q = duty;
    endfunction

    function automatic logic [3:0] exp_bridge();
        logic [3:0] r;
        r = 4'b0000;
        if (m_state[1] == M_RUN) r[3:2] = m_dir[1][1:0];
        if (m_state[0] == M_RUN) r[1:0] = m_dir[0][1:0];
        return r;
    endfunction

    function automatic logic [1:0] exp_pwm();
        logic [1:0] r;
        for (int ch = 0; ch < 2; ch++) begin
            r[ch] = (m_state[ch] == M_RUN) && ((m_cyc % PERIOD) < m_cur[ch]);
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_fault();
        return {m_fault[1] != 0, m_fault[0] != 0};
    endfunction

    // -----------------------------------------------------------------------
    // Stimulus helpers (no checking here)
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advance until the last sample shows counter 255, so the next sample
    // starts a fresh period.
    task automatic wait_wrap();
        while ((m_cyc % PERIOD) != PERIOD - 1) tick();
    endtask

    task automatic count_period(output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            if (bridge_pwm[1]) hl++;
            if (bridge_pwm[0]) hr++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        motorEn = 2'b11;
        motorIn = 4'b1001;
        duty    = 8'd200;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bridge_in !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_bridge_in: got %b required %b", bridge_in, 4'b0000);
        end
        n_cmp++;
        if (bridge_pwm !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_bridge_pwm: got %b required %b", bridge_pwm, 2'b00);
        end
        n_cmp++;
        if (dir_fault !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_dir_fault: got %b required %b", dir_fault, 2'b00);
        end
        $display("[test_reset] outputs while reset: bridge_in=%b pwm=%b fault=%b",
                 bridge_in, bridge_pwm, dir_fault);
        motorEn = 2'b00;
        motorIn = 4'b0000;
        duty    = 8'd0;
    endtask

    task automatic test_soft_start();
        int hl, hr, req;
        reset_dut();
        motorEn = 2'b11;
        motorIn = 4'b1001;
        duty    = 8'd128;
        tick();
        n_cmp++;
        if (bridge_in !== 4'b0000) begin
            n_fail++;
            $display("FAIL soft_start_edge1: got %b required %b", bridge_in, 4'b0000);
        end
        tick();
        n_cmp++;
        if (bridge_in !== 4'b1001) begin
            n_fail++;
            $display("FAIL soft_start_edge2: got %b required %b", bridge_in, 4'b1001);
        end
        wait_wrap();
        for (int p = 0; p < 5; p++) begin
            count_period(hl, hr);
            req = (32 * (p + 1) < 128) ? 32 * (p + 1) : 128;
            n_cmp++;
            if (hl !== req || hr !== req) begin
                n_fail++;
                $display("FAIL soft_start_period%0d: got left=%0d right=%0d required %0d",
                         p, hl, hr, req);
            end
            $display("[test_soft_start] period %0d high clocks left=%0d right=%0d", p, hl, hr);
        end
    endtask

    task automatic test_duty_boundaries();
        int hl, hr, tot;
        reset_dut();
        motorEn = 2'b11;
        motorIn = 4'b1010;
        duty    = 8'd0;
        repeat (2) tick();
        n_cmp++;
        if (bridge_in !== 4'b1010) begin
            n_fail++;
            $display("FAIL duty0_running: got %b required %b", bridge_in, 4'b1010);
        end
        tot = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            tick();
            if (bridge_pwm !== 2'b00) tot++;
        end
        n_cmp++;
        if (tot !== 0) begin
            n_fail++;
            $display("FAIL duty0_pwm_high: got %0d high clocks required 0", tot);
        end
        $display("[test_duty_boundaries] duty=0 high clocks over 3 periods=%0d", tot);
        duty = 8'd255;
        repeat (9 * PERIOD) tick();
        wait_wrap();
        count_period(hl, hr);
        n_cmp++;
        if (hl !== 255 || hr !== 255) begin
            n_fail++;
            $display("FAIL duty255_period: got left=%0d right=%0d required 255", hl, hr);
        end
        $display("[test_duty_boundaries] duty=255 high clocks left=%0d right=%0d", hl, hr);
    endtask

    task automatic test_reset_mid_run();
        int hl, hr;
        // Runs straight after the duty=255 scenario, mid-period.
        while ((m_cyc % PERIOD) != 100) tick();
        n_cmp++;
        if (bridge_pwm !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_run_precondition: got pwm %b required %b", bridge_pwm, 2'b11);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bridge_in !== 4'b0000 || bridge_pwm !== 2'b00 || dir_fault !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_run_async: got in=%b pwm=%b fault=%b required all zero",
                     bridge_in, bridge_pwm, dir_fault);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (bridge_in !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_mid_run_restart: got %b required %b", bridge_in, 4'b1010);
        end
        wait_wrap();
        count_period(hl, hr);
        n_cmp++;
        if (hl !== 32 || hr !== 32) begin
            n_fail++;
            $display("FAIL reset_mid_run_ramp: got left=%0d right=%0d required 32", hl, hr);
        end
        $display("[test_reset_mid_run] first period after release left=%0d right=%0d", hl, hr);
    endtask

    task automatic test_reversal();
        int zeros, pwm_bad, illegal_seen, right_bad, done, hl, hr;
        reset_dut();
        motorEn = 2'b11;
        motorIn = 4'b1001;
        duty    = 8'd128;
        repeat (1100) tick();
        motorIn = 4'b0101;
        zeros = 0; pwm_bad = 0; illegal_seen = 0; right_bad = 0; done = 0;
        for (int i = 0; i < 40 && done == 0; i++) begin
            tick();
            if (bridge_in[3:2] == 2'b11) illegal_seen++;
            if (bridge_in[1:0] != 2'b01) right_bad++;
            if (bridge_in[3:2] == 2'b00) begin
                zeros++;
                if (bridge_pwm[1]) pwm_bad++;
            end else if (bridge_in[3:2] == 2'b01) begin
                done = 1;
            end
        end
        n_cmp++;
        if (zeros !== DC || done !== 1) begin
            n_fail++;
            $display("FAIL reversal_dead_time: got %0d low clocks (reached 01=%0d) required %0d",
                     zeros, done, DC);
        end
        n_cmp++;
        if (pwm_bad !== 0 || illegal_seen !== 0) begin
            n_fail++;
            $display("FAIL reversal_safety: got pwm_in_dead=%0d pair11=%0d required 0 and 0",
                     pwm_bad, illegal_seen);
        end
        n_cmp++;
        if (right_bad !== 0) begin
            n_fail++;
            $display("FAIL reversal_right_disturbed: got %0d bad clocks required 0", right_bad);
        end
        wait_wrap();
        count_period(hl, hr);
        n_cmp++;
        if (hl !== 32 || hr !== 128) begin
            n_fail++;
            $display("FAIL reversal_ramp: got left=%0d right=%0d required left=32 right=128",
                     hl, hr);
        end
        $display("[test_reversal] dead clocks=%0d, next period left=%0d right=%0d",
                 zeros, hl, hr);
    endtask

    task automatic test_dead_glitch();
        int zeros, bad, done, left_bad;
        // Both channels run at 01 from the reversal scenario.
        motorIn = 4'b0110;
        zeros = 0; bad = 0; done = 0; left_bad = 0;
        for (int i = 0; i < 40 && done == 0; i++) begin
            tick();
            if (bridge_in[3:2] != 2'b01) left_bad++;
            if (bridge_in[1:0] == 2'b00) begin
                zeros++;
                if (zeros == 1) motorIn = 4'b0101;
                if (zeros == 5) motorIn = 4'b0110;
                if (zeros == 8) motorIn = 4'b0101;
            end else if (bridge_in[1:0] == 2'b01 && zeros > 0) begin
                done = 1;
            end else if (bridge_in[1:0] != 2'b01) begin
                bad++;
            end
        end
        n_cmp++;
        if (zeros !== DC || done !== 1 || bad !== 0) begin
            n_fail++;
            $display("FAIL dead_glitch: got low=%0d exit01=%0d other=%0d required %0d/1/0",
                     zeros, done, bad, DC);
        end
        n_cmp++;
        if (left_bad !== 0) begin
            n_fail++;
            $display("FAIL dead_glitch_left: got %0d disturbed clocks required 0", left_bad);
        end
        $display("[test_dead_glitch] right low clocks=%0d exit to 01=%0d", zeros, done);
    endtask

    task automatic test_illegal_dir();
        int hi;
        reset_dut();
        motorEn = 2'b10;
        motorIn = 4'b1100;
        duty    = 8'd128;
        repeat (2) tick();
        n_cmp++;
        if (dir_fault !== 2'b10 || bridge_in !== 4'b0000) begin
            n_fail++;
            $display("FAIL illegal_fault: got fault=%b in=%b required fault=10 in=0000",
                     dir_fault, bridge_in);
        end
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bridge_pwm !== 2'b00) hi++;
        end
        n_cmp++;
        if (hi !== 0) begin
            n_fail++;
            $display("FAIL illegal_pwm: got %0d high clocks required 0", hi);
        end
        motorIn = 4'b1000;
        repeat (2) tick();
        n_cmp++;
        if (bridge_in !== 4'b1000) begin
            n_fail++;
            $display("FAIL illegal_recover: got %b required %b", bridge_in, 4'b1000);
        end
        repeat (50) tick();
        n_cmp++;
        if (dir_fault !== 2'b10) begin
            n_fail++;
            $display("FAIL illegal_sticky: got %b required %b", dir_fault, 2'b10);
        end
        $display("[test_illegal_dir] fault=%b after legal dir returned", dir_fault);
        reset_dut();
        n_cmp++;
        if (dir_fault !== 2'b00) begin
            n_fail++;
            $display("FAIL illegal_clear: got %b required %b", dir_fault, 2'b00);
        end
    endtask

    task automatic test_back_to_back();
        int enter_l, enter_r, exit_l, exit_r, errs;
        reset_dut();
        motorEn = 2'b11;
        motorIn = 4'b1010;
        duty    = 8'($urandom_range(40, 250));
        repeat (300) tick();
        motorIn = 4'b0101;
        enter_l = -1; enter_r = -1; exit_l = -1; exit_r = -1; errs = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bridge_in !== exp_bridge() || bridge_pwm !== exp_pwm()) errs++;
            if (bridge_in[3:2] == 2'b00 && enter_l < 0) enter_l = i;
            if (bridge_in[1:0] == 2'b00 && enter_r < 0) enter_r = i;
            if (bridge_in[3:2] == 2'b01 && exit_l < 0) exit_l = i;
            if (bridge_in[1:0] == 2'b01 && exit_r < 0) exit_r = i;
        end
        n_cmp++;
        if (enter_l !== 1 || enter_r !== 1 || exit_l !== 1 + DC || exit_r !== 1 + DC) begin
            n_fail++;
            $display("FAIL b2b_reverse: got enter=%0d/%0d exit=%0d/%0d required 1/1 %0d/%0d",
                     enter_l, enter_r, exit_l, exit_r, 1 + DC, 1 + DC);
        end
        motorEn = 2'b00;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bridge_in !== exp_bridge() || bridge_pwm !== exp_pwm()) errs++;
        end
        n_cmp++;
        if (errs !== 0 || bridge_in !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_model: got %0d mismatching clocks, final in=%b required 0, 0000",
                     errs, bridge_in);
        end
        $display("[test_back_to_back] both dead at %0d/%0d, both resumed at %0d/%0d",
                 enter_l, enter_r, exit_l, exit_r);
    endtask

    function automatic logic [1:0] rand_pair();
        int r;
        r = $urandom_range(0, 15);
        if (r < 6)  return 2'b10;
        if (r < 12) return 2'b01;
        if (r < 15) return 2'b00;
        return 2'b11;
    endfunction

    task automatic test_random();
        int hold;
        logic [3:0] eb;
        logic [1:0] ep, ef;
        for (int batch = 0; batch < 2; batch++) begin
            reset_dut();
            for (int seg = 0; seg < 30; seg++) begin
                motorIn = {rand_pair(), rand_pair()};
                motorEn = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                duty    = 8'($urandom_range(0, 255));
                hold    = $urandom_range(1, 150);
                $display("[test_random] batch %0d seg %0d: in=%b en=%b duty=%0d hold=%0d",
                         batch, seg, motorIn, motorEn, duty, hold);
                for (int i = 0; i < hold; i++) begin
                    tick();
                    eb = exp_bridge();
                    ep = exp_pwm();
                    ef = exp_fault();
                    n_cmp++;
                    if (bridge_in !== eb) begin
                        n_fail++;
                        $display("FAIL rand_bridge_in cyc %0d: got %b required %b",
                                 m_cyc, bridge_in, eb);
                    end
                    n_cmp++;
                    if (bridge_pwm !== ep) begin
                        n_fail++;
                        $display("FAIL rand_bridge_pwm cyc %0d: got %b required %b",
                                 m_cyc, bridge_pwm, ep);
                    end
                    n_cmp++;
                    if (dir_fault !== ef) begin
                        n_fail++;
                        $display("FAIL rand_dir_fault cyc %0d: got %b required %b",
                                 m_cyc, dir_fault, ef);
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_soft_start();
        test_duty_boundaries();
        test_reset_mid_run();
        test_reversal();
        test_dead_glitch();
        test_illegal_dir();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
